illness_care_scheduler: RTL
===========================

// Module: illness_care_scheduler
// PURPOSE
// - Consumer side of the illness ill/illness_level outputs. Turns sickness state into care requests
//   (REST / MEDICINE / ESCALATE) for the action arbiter over a valid/ack handshake.
// - Tracks illness episodes, retries with cooldown, and pulses on recovery. Time base is the global slow tick.
// PARAMETERS
// - PRE_TICKS      8   consecutive ticks at illness_level==2'b10 (not ill) before a preventive REST
// - ACK_TIMEOUT    16  ticks in REQ without ack before code is escalated to ESCALATE
// - COOLDOWN_TICKS 32  ticks waited after an acked request before re-evaluating
// - MAX_RETRY      3   acked MEDICINE requests per episode before later requests use ESCALATE
// - CNT_W          6   tick counter width; must hold max(PRE_TICKS, ACK_TIMEOUT, COOLDOWN_TICKS)
// PORTS
// - clk            in   1   system clock
// - rst_n          in   1   asynchronous, active-low reset
// - tick           in   1   single-cycle time-base strobe; all counters advance only on tick
// - ill            in   1   sickness flag (hysteretic, from illness system)
// - illness_level  in   2   illness resource MSBs
// - care_ack       in   1   arbiter accepts the request in this cycle
// - care_valid     out  1   request pending
// - care_code      out  2   0 NONE, 1 REST, 2 MEDICINE, 3 ESCALATE
// - episode_count  out  4   illness episodes since reset, saturates at 15
// - recovered      out  1   one-cycle pulse when an episode ends
// - sick_ticks     out  12  ticks spent ill (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters, retry count and ill_d (ill delayed one cycle) cleared.
// - Rising edge of ill (ill & !ill_d) in any state: episode_count += 1 (saturating). Retry count clears.
// - IDLE: if ill, go to REQ with MEDICINE.
//   Else, on each tick with illness_level==2'b10, pre counter += 1; any other level clears it.
//   When pre counter reaches PRE_TICKS, go to REQ with REST and clear pre counter.
// - REQ: care_valid=1; care_code is registered at entry.
//   - care_code and care_valid stay stable until the ack cycle, even if ill or illness_level change.
//   - On care_ack: care_valid=0 the next cycle. If code was MEDICINE, retry += 1 (saturating at MAX_RETRY).
//     Load cooldown = COOLDOWN_TICKS and go to COOL.
//   - No ack: timeout counter += 1 per tick. When it reaches ACK_TIMEOUT and code != ESCALATE,
//     code becomes ESCALATE and the counter clears. This is the only permitted code change while valid.
//   - care_ack while care_valid=0 is ignored in every state.
// - COOL: cooldown -= 1 per tick. When it reaches 0:
//   - ill=1: go to REQ with MEDICINE if retry < MAX_RETRY, else ESCALATE.
//   - ill=0 and the last request was not REST: go to RCVD.
//   - ill=0 and the last request was REST: go to IDLE.
// - Falling edge of ill: in IDLE/COOL it is only recorded; a pending REQ still completes (valid held to ack).
//   Recovery is decided at the end of cooldown.
// - RCVD: recovered=1 for exactly one cycle, then IDLE. Retry clears.
// - Counters never wrap. A tick and an ack in the same cycle: the ack wins and the timeout counter
//   does not advance.
// - Latency: ill rising at cycle n -> care_valid=1 at n+1 (registered).
// - An asynchronous reset mid-request drops care_valid immediately; no request is replayed.
// CONFIGURATION
// - ILLNESS_CARE_STATS_EN defined: sick_ticks += 1 on each tick while ill=1, saturating at 4095,
//   cleared only by reset.
// - Not defined: sick_ticks tied to 12'd0; no counter logic is synthesised.
// TESTING
// - ill 0->1 after reset -> care_valid=1, code=2 next cycle; episode_count=1; ack -> valid=0,
//   then 32 ticks later a new MEDICINE request if still ill.
// - ill held, no ack for 16 ticks -> code 2->3, valid stays high; ack -> COOL.
// - 3 acked MEDICINE requests with ill held -> 4th request code=3 (ESCALATE).
// - illness_level=2'b10, ill=0 for 8 ticks -> REST request; after ack and 32 ticks -> IDLE, no recovered pulse.
// - ill falls during REQ -> valid held until ack; after cooldown recovered pulses once; episode 17 reads 15.
// - STATS_EN on: 100 ticks ill -> sick_ticks=100; reset mid-REQ -> all outputs 0; STATS_EN off -> sick_ticks=0.

Source files
------------

// File: rtl/illness_care_scheduler.sv
// Turns illness state into REST / MEDICINE / ESCALATE care requests over a valid/ack handshake.
// Optional sick-tick statistics counter is built only when ILLNESS_CARE_STATS_EN is defined.
module illness_care_scheduler #(
  parameter int PRE_TICKS      = 8,
  parameter int ACK_TIMEOUT    = 16,
  parameter int COOLDOWN_TICKS = 32,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_tick,
  input  logic        i_ill,
  input  logic [1:0]  i_illness_level,
  input  logic        i_care_ack,
  output logic        o_care_valid,
  output logic [1:0]  o_care_code,
  output logic [3:0]  o_episode_count,
  output logic        o_recovered,
  output logic [11:0] o_sick_ticks
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COOL, S_RCVD} state_t;

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_REST = 2'd1;
  localparam logic [1:0] CODE_MED  = 2'd2;
  localparam logic [1:0] CODE_ESC  = 2'd3;
  localparam logic [CNT_W-1:0] PRE_MAX   = CNT_W'(PRE_TICKS);
  localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] COOL_MAX  = CNT_W'(COOLDOWN_TICKS);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

  state_t           r_state, w_stateNext;
  logic [1:0]       r_code, w_codeNext;
  logic [CNT_W-1:0] r_preCnt, w_preNext;
  logic [CNT_W-1:0] r_toCnt, w_toNext;
  logic [CNT_W-1:0] r_coolCnt, w_coolNext;
  logic [RW-1:0]    r_retry, w_retryNext;
  logic [3:0]       r_episodes;
  logic             r_illD;
  logic             w_illRise;

  assign w_illRise = i_ill & ~r_illD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_code     <= CODE_NONE;
      r_preCnt   <= '0;
      r_toCnt    <= '0;
      r_coolCnt  <= '0;
      r_retry    <= '0;
      r_episodes <= '0;
      r_illD     <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_code    <= w_codeNext;
      r_preCnt  <= w_preNext;
      r_toCnt   <= w_toNext;
      r_coolCnt <= w_coolNext;
      r_retry   <= w_retryNext;
      r_illD    <= i_ill;
      if (w_illRise && r_episodes != 4'hF) begin
        r_episodes <= r_episodes + 4'd1;
      end
    end
  end

  // r_code keeps the last issued code after ack so cooldown can tell a REST episode apart.
  always_comb begin
    w_stateNext = r_state;
    w_codeNext  = r_code;
    w_preNext   = r_preCnt;
    w_toNext    = r_toCnt;
    w_coolNext  = r_coolCnt;
    w_retryNext = r_retry;
    case (r_state)
      S_IDLE: begin
        if (i_ill) begin
          w_stateNext = S_REQ;
          w_codeNext  = CODE_MED;
          w_preNext   = '0;
          w_toNext    = '0;
        end else if (i_illness_level != 2'b10) begin
          w_preNext = '0;
        end else if (i_tick) begin
          if (r_preCnt >= PRE_MAX - 1'b1) begin
            w_stateNext = S_REQ;
            w_codeNext  = CODE_REST;
            w_preNext   = '0;
            w_toNext    = '0;
          end else begin
            w_preNext = r_preCnt + 1'b1;
          end
        end
      end
      S_REQ: begin
        if (i_care_ack) begin
          if (r_code == CODE_MED && r_retry != RETRY_MAX) begin
            w_retryNext = r_retry + 1'b1;
          end
          w_coolNext  = COOL_MAX;
          w_toNext    = '0;
          w_stateNext = S_COOL;
        end else if (i_tick && r_code != CODE_ESC) begin
          if (r_toCnt >= TO_MAX - 1'b1) begin
            w_codeNext = CODE_ESC;
            w_toNext   = '0;
          end else begin
            w_toNext = r_toCnt + 1'b1;
          end
        end
      end
      S_COOL: begin
        if (r_coolCnt == '0 || (i_tick && r_coolCnt == CNT_W'(1))) begin
          w_coolNext = '0;
          if (i_ill) begin
            w_stateNext = S_REQ;
            w_codeNext  = (r_retry < RETRY_MAX) ? CODE_MED : CODE_ESC;
            w_toNext    = '0;
          end else if (r_code != CODE_REST) begin
            w_stateNext = S_RCVD;
          end else begin
            w_stateNext = S_IDLE;
          end
        end else if (i_tick) begin
          w_coolNext = r_coolCnt - 1'b1;
        end
      end
      S_RCVD: begin
        w_stateNext = S_IDLE;
        w_retryNext = '0;
      end
      default: w_stateNext = S_IDLE;
    endcase
    if (w_illRise) begin
      w_retryNext = '0;
    end
  end

  always_comb begin
    o_care_valid    = (r_state == S_REQ);
    o_care_code     = (r_state == S_REQ) ? r_code : CODE_NONE;
    o_recovered     = (r_state == S_RCVD);
    o_episode_count = r_episodes;
  end

`ifdef ILLNESS_CARE_STATS_EN
  logic [11:0] r_sickTicks;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sickTicks <= '0;
    end else if (i_tick && i_ill && r_sickTicks != 12'hFFF) begin
      r_sickTicks <= r_sickTicks + 12'd1;
    end
  end

  assign o_sick_ticks = r_sickTicks;
`else
  assign o_sick_ticks = 12'd0;
`endif

endmodule
